vga_scan_out: RTL and testbench

- Display-side counterpart to the pixel/colour renderer (drawcon).
- Generates the 1440x900@60 scan: H 1904 clocks, V 932 lines, pixel clock 106.47 MHz.
- Drives curr_x/curr_y to the renderer, samples the renderer's draw_r/g/b, and emits registered, blank-masked colour with aligned hsync/vsync to the VGA pins.
- Also provides a once-per-frame tick for game logic: position updates, level changes.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_scan_out_if.sv | 30 +++
 rtl/vga_timing_counter.sv | 72 +++++++
 rtl/vga_scan_out.sv | 94 +++++++++
 tb/tb_vga_scan_out.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for the 1440x900@60 scan (106.47 MHz pixel clock) and the
// coordinate width shared by the scan-out block and its interface.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;

  localparam int unsigned VGA_H_VIS  = 1440;
  localparam int unsigned VGA_H_FP   = 80;
  localparam int unsigned VGA_H_SYNC = 152;
  localparam int unsigned VGA_H_BP   = 232;
  localparam int unsigned VGA_V_VIS  = 900;
  localparam int unsigned VGA_V_FP   = 1;
  localparam int unsigned VGA_V_SYNC = 3;
  localparam int unsigned VGA_V_BP   = 28;
  localparam bit          VGA_H_POL  = 1'b0;
  localparam bit          VGA_V_POL  = 1'b1;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_HS_START = VGA_H_VIS + VGA_H_FP;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START = VGA_V_VIS + VGA_V_FP;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_scan_out_if.sv
// Bundle between the scan-out block, the renderer and the VGA pins.
//   master (scan-out): drives curr_x/curr_y, colour, syncs, active, frame_tick;
//                      samples draw_r/g/b.
//   slave  (renderer/display side): the reverse.
interface vga_scan_out_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] curr_x;
  logic [COORD_W-1:0] curr_y;
  logic [3:0]         draw_r;
  logic [3:0]         draw_g;
  logic [3:0]         draw_b;
  logic [3:0]         vga_r;
  logic [3:0]         vga_g;
  logic [3:0]         vga_b;
  logic               hsync;
  logic               vsync;
  logic               active;
  logic               frame_tick;

  modport master (
    input  draw_r, draw_g, draw_b,
    output curr_x, curr_y, vga_r, vga_g, vga_b, hsync, vsync, active, frame_tick
  );

  modport slave (
    output draw_r, draw_g, draw_b,
    input  curr_x, curr_y, vga_r, vga_g, vga_b, hsync, vsync, active, frame_tick
  );
endinterface

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical scan counters with raw (undelayed) decode.
//   clk, rst     : pixel clock, async active-low reset
//   hcnt, vcnt   : registered scan position
//   vis          : position is inside the visible area
//   hs_raw/vs_raw: position is inside the h/v sync pulse (active-high flags)
//   frame_tick   : registered pulse in the cycle hcnt=0, vcnt=V_VIS
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS  = VGA_H_VIS,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_VIS  = VGA_V_VIS,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] hcnt,
  output logic [COORD_W-1:0] vcnt,
  output logic               vis,
  output logic               hs_raw,
  output logic               vs_raw,
  output logic               frame_tick
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W)) begin : g_bad_total
    $error("vga_timing_counter: H_TOTAL/V_TOTAL do not fit the coordinate width");
  end

  // Constants sized to the counters so the compares stay width-matched.
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0] V_TICK_C = COORD_W'(V_VIS - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt       <= '0;
      vcnt       <= '0;
      frame_tick <= 1'b0;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) begin
        vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      end
      // Look one clock ahead so the pulse lands exactly on (0, V_VIS).
      frame_tick <= h_wrap && (vcnt == V_TICK_C);
    end
  end

  assign vis    = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  assign hs_raw = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_raw = (vcnt >= VS_START) && (vcnt < VS_END);

endmodule

// File: rtl/vga_scan_out.sv
// Display scan-out: issues coordinates to the renderer, samples its colour and
// drives blank-masked, registered RGB with hsync/vsync/active aligned to it.
//   clk, rst : pixel clock, async active-low reset
//   bus      : vga_scan_out_if.master (coordinates, renderer colour, VGA pins,
//              frame_tick)
// Outputs for the coordinate presented in cycle t appear in cycle t+PIPE_DLY.
module vga_scan_out
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS    = VGA_H_VIS,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_VIS    = VGA_V_VIS,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          H_POL    = VGA_H_POL,
  parameter bit          V_POL    = VGA_V_POL,
  parameter int unsigned PIPE_DLY = 1
) (
  input logic             clk,
  input logic             rst,
  vga_scan_out_if.master  bus
);

  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
    $error("vga_scan_out: PIPE_DLY must be in 1..4");
  end

  logic [COORD_W-1:0] hcnt;
  logic [COORD_W-1:0] vcnt;
  logic               vis;
  logic               hs_raw;
  logic               vs_raw;
  logic               frame_tick;

  vga_timing_counter #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .vis        (vis),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .frame_tick (frame_tick)
  );

  // Delay lines hold active-high flags; bit i has been registered i+1 times.
  logic [PIPE_DLY-1:0] vis_q;
  logic [PIPE_DLY-1:0] hs_q;
  logic [PIPE_DLY-1:0] vs_q;
  logic [PIPE_DLY:0]   vis_all;
  logic [11:0]         rgb_q;

  // vis_all[i] is vis delayed by i clocks (bit 0 is the raw decode).
  assign vis_all = {vis_q, vis};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
      rgb_q <= '0;
    end else begin
      vis_q <= PIPE_DLY'({vis_q, vis});
      hs_q  <= PIPE_DLY'({hs_q, hs_raw});
      vs_q  <= PIPE_DLY'({vs_q, vs_raw});
      // Renderer colour arrives PIPE_DLY-1 clocks after its coordinate, so
      // mask it with vis delayed by the same amount; porch colour never leaks.
      rgb_q <= vis_all[PIPE_DLY-1] ? {bus.draw_r, bus.draw_g, bus.draw_b} : 12'h000;
    end
  end

  assign bus.curr_x     = hcnt;
  assign bus.curr_y     = vcnt;
  assign bus.vga_r      = rgb_q[11:8];
  assign bus.vga_g      = rgb_q[7:4];
  assign bus.vga_b      = rgb_q[3:0];
  assign bus.active     = vis_all[PIPE_DLY];
  assign bus.hsync      = hs_q[PIPE_DLY-1] ? H_POL : ~H_POL;
  assign bus.vsync      = vs_q[PIPE_DLY-1] ? V_POL : ~V_POL;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomized bench: one full-size instance (PIPE_DLY=1) and one reduced-timing
// instance (PIPE_DLY=3, inverted polarities) checked every cycle against a
// reference computed from the elapsed clock count.
module tb_vga_scan_out;
  import vga_timing_pkg::*;

  localparam int S_HV = 16, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VV = 8,  S_VFP = 1, S_VS = 3, S_VBP = 2;
  localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_scan_out_if bus_a ();
  vga_scan_out_if bus_b ();

  vga_scan_out #(
    .PIPE_DLY (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  vga_scan_out #(
    .H_VIS (S_HV), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_VIS (S_VV), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .H_POL (1'b1), .V_POL (1'b0), .PIPE_DLY (3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [37:0] obs_a, obs_b;
  assign obs_a = {bus_a.curr_x, bus_a.curr_y, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b,
                  bus_a.hsync, bus_a.vsync, bus_a.active, bus_a.frame_tick};
  assign obs_b = {bus_b.curr_x, bus_b.curr_y, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b,
                  bus_b.hsync, bus_b.vsync, bus_b.active, bus_b.frame_tick};

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;                 // clock edges since reset release
  logic [11:0] cur_draw = '0; // colour currently driven to both renderers

  // Bookkeeping measured from the DUTs, compared against fixed expectations.
  int  a_fall = -1, a_low = 0, a_width = -1;
  logic a_prev_hs = 1'b1;
  int  b_last_tick = -1, b_vs_cnt = 0, b_gaps = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Expected outputs in cycle kk: coordinate from kk, decode of the coordinate
  // from kk-p, colour = renderer value of the previous cycle when visible.
  function automatic logic [37:0] model(input int kk, input int p,
                                        input int hv, input int hfp, input int hsw,
                                        input int hbp, input int vv, input int vfp,
                                        input int vsw, input int vbp,
                                        input bit hpol, input bit vpol,
                                        input logic [11:0] draw_prev);
    int ht, vt, x, y, cx, cy;
    bit hs, vs, act, tick;
    logic [11:0] rgb;
    logic [10:0] x11, y11;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    x = kk % ht;
    y = (kk / ht) % vt;
    tick = (x == 0) && (y == vv);
    hs = 1'b0; vs = 1'b0; act = 1'b0; rgb = '0;
    if (kk >= p) begin
      cx = (kk - p) % ht;
      cy = ((kk - p) / ht) % vt;
      hs = (cx >= hv + hfp) && (cx < hv + hfp + hsw);
      vs = (cy >= vv + vfp) && (cy < vv + vfp + vsw);
      act = (cx < hv) && (cy < vv);
      if (act) rgb = draw_prev;
    end
    x11 = 11'(x);
    y11 = 11'(y);
    return {x11, y11, rgb, hs ? hpol : ~hpol, vs ? vpol : ~vpol, act, tick};
  endfunction

  function automatic logic [37:0] model_a(input int kk);
    return model(kk, 1, VGA_H_VIS, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
                 VGA_V_VIS, VGA_V_FP, VGA_V_SYNC, VGA_V_BP, 1'b0, 1'b1, cur_draw);
  endfunction

  function automatic logic [37:0] model_b(input int kk);
    return model(kk, 3, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP,
                 1'b1, 1'b0, cur_draw);
  endfunction

  task automatic drive_draw();
    cur_draw = 12'($urandom);
    bus_a.draw_r = cur_draw[11:8]; bus_a.draw_g = cur_draw[7:4]; bus_a.draw_b = cur_draw[3:0];
    bus_b.draw_r = cur_draw[11:8]; bus_b.draw_g = cur_draw[7:4]; bus_b.draw_b = cur_draw[3:0];
  endtask

  task automatic track();
    if (a_prev_hs && !bus_a.hsync && a_fall < 0) a_fall = k;
    if (!bus_a.hsync) a_low++;
    else begin
      if (a_low > 0 && a_width < 0) a_width = a_low;
      a_low = 0;
    end
    a_prev_hs = bus_a.hsync;
    if (bus_b.frame_tick) begin
      if (b_last_tick >= 0) begin
        check("b_tick_gap", 64'(k - b_last_tick), 64'(S_HT * S_VT));
        check("b_vs_per_frame", 64'(b_vs_cnt), 64'(S_VS * S_HT));
        b_gaps++;
      end
      b_last_tick = k;
      b_vs_cnt = 0;
    end
    if (bus_b.vsync == 1'b0) b_vs_cnt++;
  endtask

  // One clock: advance, sample on the falling edge, compare, drive new colour.
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    check("a_vec", obs_a, model_a(k));
    check("b_vec", obs_b, model_b(k));
    track();
    drive_draw();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    b_last_tick = -1;
    b_vs_cnt = 0;
    check("a_release", obs_a, model_a(0));
    check("b_release", obs_b, model_b(0));
    drive_draw();
  endtask

  initial begin
    bit found;
    drive_draw();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset", obs_a, model_a(0));
    check("b_reset", obs_b, model_b(0));
    release_rst();

    repeat (4000) step();
    check("a_hs_fall_k", 64'(a_fall), 64'(VGA_HS_START + 1));
    check("a_hs_width", 64'(a_width), 64'(VGA_H_SYNC));
    check("b_frames_seen", 64'(b_gaps >= 7), 64'(1));

    // Reach a point where dut_b's delayed outputs sit inside both sync pulses.
    found = 1'b0;
    for (int i = 0; i < 2 * S_HT * S_VT && !found; i++) begin
      step();
      found = (k % S_HT == S_HV + S_HFP + 5) && ((k / S_HT) % S_VT == S_VV + S_VFP + 1);
    end
    check("b_rst_point", 64'(found), 64'(1));
    check("b_in_syncs", {62'(0), bus_b.hsync, bus_b.vsync}, {62'(0), 1'b1, 1'b0});

    // Asynchronous assertion: outputs must drop with no clock edge.
    #2 rst = 1'b0;
    #1;
    check("a_async_rst", obs_a, model_a(0));
    check("b_async_rst", obs_b, model_b(0));
    release_rst();
    repeat (1500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
